// File: rtl/tt_input_debounce.sv
// rtl/tt_input_debounce.sv - per-bit synchroniser and debouncer for raw tile inputs
// Each channel gives a clean level, one-cycle rise/fall pulses and a rise-toggle bit.
`timescale 1ns/1ps

module tt_input_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] toggle_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] toggle;
  logic [CNT_W-1:0] cnt [WIDTH];

  // The synchroniser keeps running while ena is low so the chain is fresh on re-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable     <= '0;
      toggle     <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!ena) begin
          cnt[i] <= '0;
        end else if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] < CNT_LAST) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else begin
          // Mismatch has persisted DEBOUNCE_CYCLES cycles: accept the new level.
          stable[i]     <= sync2[i];
          cnt[i]        <= '0;
          rise_pulse[i] <= sync2[i];
          fall_pulse[i] <= !sync2[i];
          if (sync2[i]) begin
            toggle[i] <= !toggle[i];
          end
        end
      end
    end
  end

  assign level_out  = stable;
  assign toggle_out = toggle;

endmodule
